// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the SR latch driver.
// Optional feature macro: SR_DRV_FORCE_EN (re-pulse every channel on request).
package sr_drv_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, PULSE, GAP} sr_drv_state_e;

    // Default pulse length; the recovery gap defaults to half of it.
    localparam int SR_DRV_DEF_PULSE = 4;
    localparam int SR_DRV_DEF_GAP   = SR_DRV_DEF_PULSE / 2;

    function automatic int sr_drv_cnt_width(input int pulse_cycles, input int gap_cycles);
        int longest;
        longest = (pulse_cycles > gap_cycles) ? pulse_cycles : gap_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Target-word request channel of the SR latch driver.
// req_force exists only when SR_DRV_FORCE_EN is defined.
interface sr_latch_driver_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_state;
`ifdef SR_DRV_FORCE_EN
    logic             req_force;

    modport master (output req_valid, output req_state, output req_force, input req_ready);
    modport slave  (input req_valid, input req_state, input req_force, output req_ready);
`else
    modport master (output req_valid, output req_state, input req_ready);
    modport slave  (input req_valid, input req_state, output req_ready);
`endif
endinterface

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter shared by the pulse and gap phases; done is high while the count is zero.
module sr_pulse_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    assign done = (cnt_reg == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Sequences set/reset pulses to a bank of SR latches, one channel at a time, skipping matched channels.
// Define SR_DRV_FORCE_EN to add req_force, which re-pulses every channel in the sequence.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int PULSE_CYCLES = SR_DRV_DEF_PULSE,
    parameter int GAP_CYCLES   = SR_DRV_DEF_GAP
) (
    input  logic             clk,
    input  logic             rst_n,
    sr_latch_driver_if.slave req,
    output logic [WIDTH-1:0] set_o,
    output logic [WIDTH-1:0] reset_o,
    output logic [WIDTH-1:0] state_o,
    output logic             busy,
    output logic             synced
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = sr_drv_cnt_width(PULSE_CYCLES, GAP_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    sr_drv_state_e    state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [WIDTH-1:0] target_reg;
    logic [WIDTH-1:0] shadow_reg;
    logic             synced_reg, synced_next;
    logic             force_sel;
    logic             accept;
    logic             shadow_wr;
    logic             need;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_done;

`ifdef SR_DRV_FORCE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            force_sel <= 1'b0;
        end else if (accept) begin
            force_sel <= req.req_force;
        end
    end
`else
    assign force_sel = 1'b0;
`endif

    // Until every latch has been driven once its real state is unknown, so all channels need a pulse.
    assign need = !synced_reg || force_sel || (target_reg[idx_reg] ^ shadow_reg[idx_reg]);

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        synced_next = synced_reg;
        accept      = 1'b0;
        shadow_wr   = 1'b0;
        timer_load  = 1'b0;
        timer_val   = PULSE_LOAD;
        unique case (state_reg)
            IDLE: begin
                if (req.req_valid) begin
                    accept     = 1'b1;
                    idx_next   = '0;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (need) begin
                    timer_load = 1'b1;
                    timer_val  = PULSE_LOAD;
                    state_next = PULSE;
                end else if (idx_reg == LAST_IDX) begin
                    synced_next = 1'b1;
                    state_next  = IDLE;
                end else begin
                    idx_next = idx_reg + IDX_W'(1);
                end
            end
            PULSE: begin
                if (timer_done) begin
                    shadow_wr  = 1'b1;
                    timer_load = 1'b1;
                    timer_val  = GAP_LOAD;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (timer_done) begin
                    if (idx_reg == LAST_IDX) begin
                        synced_next = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        idx_next   = idx_reg + IDX_W'(1);
                        state_next = SCAN;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            target_reg <= '0;
            shadow_reg <= '0;
            synced_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            synced_reg <= synced_next;
            if (accept) begin
                target_reg <= req.req_state;
            end
            if (shadow_wr) begin
                shadow_reg[idx_reg] <= target_reg[idx_reg];
            end
        end
    end

    sr_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out
        logic sel;
        assign sel         = (state_reg == PULSE) && (idx_reg == IDX_W'(gi));
        assign set_o[gi]   = sel && target_reg[gi];
        assign reset_o[gi] = sel && !target_reg[gi];
    end

    assign state_o       = shadow_reg;
    assign synced        = synced_reg;
    assign busy          = (state_reg != IDLE);
    assign req.req_ready = (state_reg == IDLE);

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed and randomized checks of sr_latch_driver against a timeline model built from the pulse rules.
module tb_sr_latch_driver;
    localparam int W = 8;
    localparam int P = 4;
    localparam int G = 2;
`ifdef SR_DRV_FORCE_EN
    localparam bit FORCE_ON = 1'b1;
`else
    localparam bit FORCE_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] set_o, reset_o, state_o;
    logic         busy, synced;

    sr_latch_driver_if #(.WIDTH(W)) req ();

    sr_latch_driver #(.WIDTH(W), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .set_o   (set_o),
        .reset_o (reset_o),
        .state_o (state_o),
        .busy    (busy),
        .synced  (synced)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] m_shadow = '0;
    logic         m_synced = 1'b0;
    logic [28:0]  obs_q[$];
    logic [28:0]  exp_q[$];
    int           obs_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse record: channel, polarity (1=set), start cycle after accept, width.
    function automatic logic [28:0] pk(input int ch, input logic pol, input int start, input int width);
        return {8'(ch), pol, 12'(start), 8'(width)};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("no_overlap", 64'(set_o & reset_o), 64'(0));
            check("onehot0", 64'($onehot0(set_o | reset_o)), 64'(1));
        end
    end

    // Each channel costs one scan cycle, plus pulse and gap when it needs driving.
    task automatic model(input logic [W-1:0] w, input logic f, output int total);
        int t;
        t = 0;
        exp_q.delete();
        for (int ch = 0; ch < W; ch++) begin
            if (!m_synced || (f && FORCE_ON) || (w[ch] != m_shadow[ch])) begin
                exp_q.push_back(pk(ch, w[ch], t + 1, P));
                t += 1 + P + G;
            end else begin
                t += 1;
            end
        end
        total    = t;
        m_shadow = w;
        m_synced = 1'b1;
    endtask

    task automatic drive(input logic [W-1:0] w, input logic f);
        req.req_state = w;
`ifdef SR_DRV_FORCE_EN
        req.req_force = f;
`else
        if (f) req.req_state = w;
`endif
    endtask

    task automatic start_req(input logic [W-1:0] w, input logic f);
        @(negedge clk);
        check("ready_before_req", 64'(req.req_ready), 64'(1));
        req.req_valid = 1'b1;
        drive(w, f);
        @(posedge clk);
        #1 req.req_valid = 1'b0;
    endtask

    task automatic observe(input bit jitter);
        bit           act;
        int           a_ch, a_start, a_w;
        logic         a_pol;
        logic [W-1:0] lv;
        obs_q.delete();
        obs_done = -1;
        act = 0;
        a_ch = 0; a_start = 0; a_w = 0; a_pol = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            lv = set_o | reset_o;
            if (lv != '0) begin
                if (!act) begin
                    act = 1;
                    for (int b = W - 1; b >= 0; b--) if (lv[b]) a_ch = b;
                    a_pol = |set_o;
                    a_start = n;
                    a_w = 1;
                end else begin
                    a_w++;
                end
            end else if (act) begin
                obs_q.push_back(pk(a_ch, a_pol, a_start, a_w));
                act = 0;
            end
            if (req.req_ready) begin
                obs_done = n;
                break;
            end
            if (jitter) req.req_state = W'($urandom);
        end
    endtask

    task automatic compare(input string tag, input int total);
        int n;
        check({tag, "_npulses"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_pulse"}, 64'(obs_q[i]), 64'(exp_q[i]));
        check({tag, "_ready_cycle"}, 64'(obs_done), 64'(total));
        check({tag, "_state_o"}, 64'(state_o), 64'(m_shadow));
        check({tag, "_synced"}, 64'(synced), 64'(1));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        $display("seq %s: %0d pulses, ready after %0d cycles, state_o=%h", tag, obs_q.size(), obs_done, state_o);
    endtask

    task automatic run(input logic [W-1:0] w, input logic f, input string tag);
        int total;
        model(w, f, total);
        start_req(w, f);
        observe(0);
        compare(tag, total);
    endtask

    initial begin
        int           total;
        bit           found;
        logic [W-1:0] w;
        req.req_valid = 1'b0;
        drive('0, 1'b0);

        #12;
        check("rst_set_o", 64'(set_o), 64'(0));
        check("rst_reset_o", 64'(reset_o), 64'(0));
        check("rst_state_o", 64'(state_o), 64'(0));
        check("rst_synced", 64'(synced), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(req.req_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;

        run(8'h00, 1'b0, "first_sync");
        run(8'hA5, 1'b0, "a5");
        run(8'hA5, 1'b0, "a5_repeat");

        // Request all-mismatch word, then pull reset while channel 2 is pulsing.
        start_req(8'h5A, 1'b0);
        found = 0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if ((set_o[2] | reset_o[2]) == 1'b1) found = 1;
        end
        check("ch2_pulse_seen", 64'(found), 64'(1));
        rst_n = 1'b0;
        #1;
        check("midrst_set_o", 64'(set_o), 64'(0));
        check("midrst_reset_o", 64'(reset_o), 64'(0));
        check("midrst_synced", 64'(synced), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_ready", 64'(req.req_ready), 64'(1));
        check("midrst_state_o", 64'(state_o), 64'(0));
        m_shadow = '0;
        m_synced = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run(8'hA5, 1'b0, "after_midrst");

        // Valid held high with a changing word while busy; the next accept lands on the IDLE cycle.
        model(8'h3C, 1'b0, total);
        @(negedge clk);
        req.req_valid = 1'b1;
        drive(8'h3C, 1'b0);
        @(posedge clk);
        observe(1);
        compare("hold_first", total);
        drive(8'hC3, 1'b0);
        model(8'hC3, 1'b0, total);
        @(posedge clk);
        #1 req.req_valid = 1'b0;
        observe(0);
        compare("hold_second", total);

        run(8'hA5, 1'b0, "pre_force");
        run(8'hA5, 1'b1, "force_a5");

        for (int i = 0; i < 8; i++) begin
            w = W'($urandom);
            run(w, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
